mem_stage_wb: RTL and testbench

- MIPS memory-access stage plus MEM/WB pipeline register.
- Consumes the EX/MEM register outputs: WB/M control, ALU result, store data and destination register.
- Drives a variable-latency data memory over a req/ack handshake and raises `stall` to freeze upstream stages while an access is pending.
- Registers the write-back bundle for the WB stage.

---
 rtl/mem_stage_wb_if.sv | 45 ++++
 rtl/mem_stage_wb.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_wb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_wb_if.sv
// -----------------------------------------------------------------------------
// mem_stage_wb_if
//
// Purpose:
//   Data-memory request/acknowledge bus between the MIPS memory-access stage
//   and a variable-latency data memory.
//
// Signals:
//   dmem_req    stage -> memory  access request, held until dmem_ack
//   dmem_we     stage -> memory  1 = write, 0 = read
//   dmem_addr   stage -> memory  word address (low two bits always zero)
//   dmem_wdata  stage -> memory  store data
//   dmem_ack    memory -> stage  access complete; dmem_rdata valid same cycle
//   dmem_rdata  memory -> stage  load data
//
// Modports:
//   master  used by the memory stage
//   slave   used by the memory model / memory controller
// -----------------------------------------------------------------------------
interface mem_stage_wb_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_wb.sv
// -----------------------------------------------------------------------------
// mem_stage_wb
//
// Purpose:
//   MIPS memory-access stage together with the MEM/WB pipeline register.
//   Takes the EX/MEM bundle, performs the data-memory access over a
//   req/ack handshake, freezes the upstream stages with 'stall' while the
//   access is outstanding and registers the write-back bundle.
//
// Parameters:
//   TIMEOUT  cycles to wait for dmem_ack before aborting (0 = wait forever)
//   CNT_W    width of the wait counter, 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   WB           in   {RegWrite, MemtoReg} from EX/MEM
//   M            in   {Branch, MemRead, MemWrite} from EX/MEM (Branch unused)
//   ALUOut       in   ALU result / memory address
//   WriteDataIn  in   store data
//   RegRD        in   destination register
//   dmem         bus  data-memory handshake (mem_stage_wb_if.master)
//   stall        out  hold EX/MEM and all earlier stages this cycle
//   WBreg        out  registered WB control
//   ReadDataOut  out  registered load data
//   ALUreg       out  registered ALU result
//   RegRDreg     out  registered destination register
//   bus_err      out  one-cycle pulse on a timeout abort (or misaligned access)
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN  when defined, an access whose address is not word
//                       aligned is not issued; it is dropped with a bus_err
//                       pulse. When undefined, the low address bits are
//                       simply ignored.
// -----------------------------------------------------------------------------
module mem_stage_wb #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            WB,
    input  logic [2:0]            M,
    input  logic [31:0]           ALUOut,
    input  logic [31:0]           WriteDataIn,
    input  logic [4:0]            RegRD,
    mem_stage_wb_if.master        dmem,
    output logic                  stall,
    output logic [1:0]            WBreg,
    output logic [31:0]           ReadDataOut,
    output logic [31:0]           ALUreg,
    output logic [4:0]            RegRDreg,
    output logic                  bus_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Copy of the instruction being serviced while the memory is slow.
    logic [1:0]       hold_wb;
    logic             hold_we;
    logic [31:0]      hold_alu;
    logic [31:0]      hold_wdata;
    logic [4:0]       hold_rd;

    logic             access;
    logic             misaligned;
    logic             issue;
    logic             timeout_hit;

    logic             req_c;
    logic             we_c;
    logic [31:0]      addr_c;
    logic [31:0]      wdata_c;
    logic             stall_c;
    logic             bus_err_c;

    // Branch has already been resolved earlier in the pipe.
    logic             unused_branch;
    assign unused_branch = M[2];

    assign access = M[1] | M[0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (ALUOut[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign issue       = access & ~misaligned;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT);

    // Handshake, stall and error outputs. In IDLE the bus follows the
    // EX/MEM inputs directly so a fast memory can answer in the same cycle;
    // in WAIT it is driven from the holding registers so the address and
    // data stay stable no matter what upstream presents. Reset overrides
    // everything so an abandoned access is never re-requested.
    always_comb begin
        req_c     = 1'b0;
        we_c      = M[0];
        addr_c    = {ALUOut[31:2], 2'b00};
        wdata_c   = WriteDataIn;
        stall_c   = 1'b0;
        bus_err_c = 1'b0;
        case (state)
            S_IDLE: begin
                req_c     = issue;
                stall_c   = issue & ~dmem.dmem_ack;
                bus_err_c = access & misaligned;
            end
            S_WAIT: begin
                req_c     = 1'b1;
                we_c      = hold_we;
                addr_c    = {hold_alu[31:2], 2'b00};
                wdata_c   = hold_wdata;
                stall_c   = ~dmem.dmem_ack & ~timeout_hit;
                bus_err_c = ~dmem.dmem_ack & timeout_hit;
            end
            default: begin
                req_c = 1'b0;
            end
        endcase
        if (reset) begin
            req_c     = 1'b0;
            stall_c   = 1'b0;
            bus_err_c = 1'b0;
        end
    end

    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = we_c;
    assign dmem.dmem_addr  = addr_c;
    assign dmem.dmem_wdata = wdata_c;
    assign stall           = stall_c;
    assign bus_err         = bus_err_c;

    // Access FSM and MEM/WB register. A bubble only clears WBreg so that
    // no register write happens; the data fields keep their old values.
    // Stores never return data, so ReadDataOut is forced to zero for them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            hold_wb     <= '0;
            hold_we     <= 1'b0;
            hold_alu    <= '0;
            hold_wdata  <= '0;
            hold_rd     <= '0;
            WBreg       <= '0;
            ReadDataOut <= '0;
            ALUreg      <= '0;
            RegRDreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (dmem.dmem_ack) begin
                            WBreg       <= WB;
                            ReadDataOut <= M[0] ? 32'h0 : dmem.dmem_rdata;
                            ALUreg      <= ALUOut;
                            RegRDreg    <= RegRD;
                        end else begin
                            hold_wb    <= WB;
                            hold_we    <= M[0];
                            hold_alu   <= ALUOut;
                            hold_wdata <= WriteDataIn;
                            hold_rd    <= RegRD;
                            wait_cnt   <= CNT_W'(1);
                            state      <= S_WAIT;
                            WBreg      <= '0;
                        end
                    end else if (access) begin
                        WBreg <= '0;
                    end else begin
                        WBreg       <= WB;
                        ReadDataOut <= '0;
                        ALUreg      <= ALUOut;
                        RegRDreg    <= RegRD;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ack) begin
                        WBreg       <= hold_wb;
                        ReadDataOut <= hold_we ? 32'h0 : dmem.dmem_rdata;
                        ALUreg      <= hold_alu;
                        RegRDreg    <= hold_rd;
                        wait_cnt    <= '0;
                        state       <= S_IDLE;
                    end else if (timeout_hit) begin
                        WBreg    <= '0;
                        wait_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        WBreg    <= '0;
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_wb
//
// Purpose:
//   Directed self-checking bench for mem_stage_wb, built with TIMEOUT=4.
//   Inputs change 1 ns after a rising edge, combinational outputs are
//   sampled 1 ns later, registered outputs 1 ns after the next rising edge.
//
// Build option:
//   MEM_ALIGN_CHECK_EN selects which misaligned-access behaviour is expected.
// -----------------------------------------------------------------------------
module tb_mem_stage_wb;

    logic        clock;
    logic        reset;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic [31:0] ALUOut;
    logic [31:0] WriteDataIn;
    logic [4:0]  RegRD;
    logic        stall;
    logic [1:0]  WBreg;
    logic [31:0] ReadDataOut;
    logic [31:0] ALUreg;
    logic [4:0]  RegRDreg;
    logic        bus_err;

    int checkCount = 0;
    int errorCount = 0;

    mem_stage_wb_if dmem ();

    mem_stage_wb #(
        .TIMEOUT (4),
        .CNT_W   (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .WB          (WB),
        .M           (M),
        .ALUOut      (ALUOut),
        .WriteDataIn (WriteDataIn),
        .RegRD       (RegRD),
        .dmem        (dmem),
        .stall       (stall),
        .WBreg       (WBreg),
        .ReadDataOut (ReadDataOut),
        .ALUreg      (ALUreg),
        .RegRDreg    (RegRDreg),
        .bus_err     (bus_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one EX/MEM bundle plus the memory response, then let the
    // combinational outputs settle.
    task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic ack,
                                 input logic [31:0] rdata);
        WB              = wb;
        M               = m;
        ALUOut          = alu;
        WriteDataIn     = wd;
        RegRD           = rd;
        dmem.dmem_ack   = ack;
        dmem.dmem_rdata = rdata;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_req", 32'(dmem.dmem_req), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_wbreg", 32'(WBreg), 32'h0);
        checkOutput("rst_alureg", ALUreg, 32'h0);
        checkOutput("rst_rdout", ReadDataOut, 32'h0);
        reset = 1'b0;

        // Non-memory op passes straight through
        applyStimulus(2'b10, 3'b000, 32'h1234, 32'hCAFE, 5'd5, 1'b0, 32'h0);
        checkOutput("alu_stall", 32'(stall), 32'h0);
        checkOutput("alu_req", 32'(dmem.dmem_req), 32'h0);
        nextCycle();
        checkOutput("alu_wbreg", 32'(WBreg), 32'h2);
        checkOutput("alu_alureg", ALUreg, 32'h1234);
        checkOutput("alu_rdreg", 32'(RegRDreg), 32'd5);
        checkOutput("alu_rdout", ReadDataOut, 32'h0);

        // Zero-wait load
        applyStimulus(2'b11, 3'b010, 32'h40, 32'h0, 5'd8, 1'b1, 32'hDEADBEEF);
        checkOutput("zw_stall", 32'(stall), 32'h0);
        checkOutput("zw_req", 32'(dmem.dmem_req), 32'h1);
        checkOutput("zw_we", 32'(dmem.dmem_we), 32'h0);
        checkOutput("zw_addr", dmem.dmem_addr, 32'h40);
        nextCycle();
        checkOutput("zw_rdout", ReadDataOut, 32'hDEADBEEF);
        checkOutput("zw_wbreg", 32'(WBreg), 32'h3);
        checkOutput("zw_rdreg", 32'(RegRDreg), 32'd8);

        // 3-cycle store: two stall cycles, ack on the third
        applyStimulus(2'b01, 3'b001, 32'h80, 32'hA5A5A5A5, 5'd2, 1'b0, 32'h0);
        checkOutput("st1_stall", 32'(stall), 32'h1);
        checkOutput("st1_we", 32'(dmem.dmem_we), 32'h1);
        checkOutput("st1_addr", dmem.dmem_addr, 32'h80);
        nextCycle();
        checkOutput("st1_wbreg", 32'(WBreg), 32'h0);
        // Upstream garbage during WAIT must not disturb the held access
        applyStimulus(2'b10, 3'b010, 32'hFFFFFFFC, 32'h0, 5'd31, 1'b0, 32'h0);
        checkOutput("st2_stall", 32'(stall), 32'h1);
        checkOutput("st2_req", 32'(dmem.dmem_req), 32'h1);
        checkOutput("st2_addr", dmem.dmem_addr, 32'h80);
        checkOutput("st2_wdata", dmem.dmem_wdata, 32'hA5A5A5A5);
        checkOutput("st2_we", 32'(dmem.dmem_we), 32'h1);
        nextCycle();
        checkOutput("st2_wbreg", 32'(WBreg), 32'h0);
        applyStimulus(2'b10, 3'b010, 32'hFFFFFFFC, 32'h0, 5'd31, 1'b1, 32'h77777777);
        checkOutput("st3_stall", 32'(stall), 32'h0);
        checkOutput("st3_addr", dmem.dmem_addr, 32'h80);
        nextCycle();
        checkOutput("st3_wbreg", 32'(WBreg), 32'h1);
        checkOutput("st3_alureg", ALUreg, 32'h80);
        checkOutput("st3_rdreg", 32'(RegRDreg), 32'd2);
        checkOutput("st3_rdout", ReadDataOut, 32'h0);

        // Back-to-back zero-wait access with both MemRead and MemWrite: write wins
        applyStimulus(2'b10, 3'b011, 32'h100, 32'h11112222, 5'd6, 1'b1, 32'h99999999);
        checkOutput("bb_req", 32'(dmem.dmem_req), 32'h1);
        checkOutput("bb_we", 32'(dmem.dmem_we), 32'h1);
        checkOutput("bb_wdata", dmem.dmem_wdata, 32'h11112222);
        nextCycle();
        checkOutput("bb_rdout", ReadDataOut, 32'h0);
        checkOutput("bb_wbreg", 32'(WBreg), 32'h2);

        // Timeout: four stall cycles, then a one-cycle abort with bus_err
        applyStimulus(2'b11, 3'b010, 32'h104, 32'h0, 5'd7, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("to_stall%0d", i), 32'(stall), 32'h1);
            checkOutput($sformatf("to_err%0d", i), 32'(bus_err), 32'h0);
            nextCycle();
            checkOutput($sformatf("to_wbreg%0d", i), 32'(WBreg), 32'h0);
        end
        checkOutput("to_abort_stall", 32'(stall), 32'h0);
        checkOutput("to_abort_err", 32'(bus_err), 32'h1);
        checkOutput("to_abort_req", 32'(dmem.dmem_req), 32'h1);
        nextCycle();
        checkOutput("to_abort_wbreg", 32'(WBreg), 32'h0);
        applyStimulus(2'b10, 3'b000, 32'h200, 32'h0, 5'd9, 1'b0, 32'h0);
        checkOutput("to_idle_err", 32'(bus_err), 32'h0);
        checkOutput("to_idle_stall", 32'(stall), 32'h0);
        nextCycle();
        checkOutput("to_idle_wbreg", 32'(WBreg), 32'h2);
        checkOutput("to_idle_alureg", ALUreg, 32'h200);

        // Reset on the second stall cycle abandons the load
        applyStimulus(2'b11, 3'b010, 32'h300, 32'h0, 5'd3, 1'b0, 32'h0);
        checkOutput("rw_stall", 32'(stall), 32'h1);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("rw_req_in_reset", 32'(dmem.dmem_req), 32'h0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        checkOutput("rw_req", 32'(dmem.dmem_req), 32'h0);
        checkOutput("rw_stall_after", 32'(stall), 32'h0);
        checkOutput("rw_wbreg", 32'(WBreg), 32'h0);
        checkOutput("rw_alureg", ALUreg, 32'h0);
        checkOutput("rw_rdreg", 32'(RegRDreg), 32'h0);
        checkOutput("rw_rdout", ReadDataOut, 32'h0);
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1, 32'h55555555);
        nextCycle();
        checkOutput("rw_late_wbreg", 32'(WBreg), 32'h0);
        checkOutput("rw_late_rdout", ReadDataOut, 32'h0);

        // Misaligned load
        applyStimulus(2'b11, 3'b010, 32'h42, 32'h0, 5'd4, 1'b1, 32'h12345678);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("al_req", 32'(dmem.dmem_req), 32'h0);
        checkOutput("al_err", 32'(bus_err), 32'h1);
        checkOutput("al_stall", 32'(stall), 32'h0);
        nextCycle();
        checkOutput("al_wbreg", 32'(WBreg), 32'h0);
`else
        checkOutput("al_req", 32'(dmem.dmem_req), 32'h1);
        checkOutput("al_addr", dmem.dmem_addr, 32'h40);
        checkOutput("al_err", 32'(bus_err), 32'h0);
        nextCycle();
        checkOutput("al_rdout", ReadDataOut, 32'h12345678);
        checkOutput("al_alureg", ALUreg, 32'h42);
        checkOutput("al_wbreg", 32'(WBreg), 32'h3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
